// File: rtl/uart_pkg.sv
// Shared types and the oversample NCO increment helper for the UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;

  localparam int OVERSAMPLE = 16;

  // Rounded phase increment giving OVERSAMPLE carries per bit time.
  function automatic int unsigned nco_incr(input real clk_freq, input real baud, input int width);
    real ratio;
    ratio = (2.0 ** width) * baud * OVERSAMPLE / clk_freq;
    return int'($rtoi(ratio + 0.5));
  endfunction

endpackage

// File: rtl/uart_rx_stream_fifo.sv
// Synchronous FIFO holding received frames; a pop frees a slot for a same-cycle push.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  // Gate the head so the stream data reads zero whenever nothing is queued.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver with 16x NCO oversampling, parity/frame/break detection and a stream FIFO.
//   state     | meaning
//   ST_IDLE   | line idle, looking for a 1->0 edge (or waiting for high after a break)
//   ST_START  | half a bit in, confirming the start bit is still low
//   ST_DATA   | sampling DATA_BITS data bits mid-bit, LSB first
//   ST_PARITY | sampling the parity bit
//   ST_STOP   | sampling STOP_BITS stop bits, then push or flag a break
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter real     CLK_FREQ   = 100E6,
  parameter int      BAUD_RATE  = 115200,
  parameter int      NCO_WIDTH  = 16,
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overrun,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_stream: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_stream: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_rx_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int unsigned          NCO_INCR_I = nco_incr(CLK_FREQ, real'(BAUD_RATE), NCO_WIDTH);
  localparam logic [NCO_WIDTH-1:0] NCO_INCR   = NCO_INCR_I[NCO_WIDTH-1:0];
  localparam int                   EW         = DATA_BITS + 2;
  localparam logic [3:0]           HALF_LAST  = 4'd7;
  localparam logic [3:0]           BIT_LAST   = 4'd15;
  localparam logic [2:0]           DATA_FIRST = 3'(DATA_BITS - 1);
  localparam logic                 STOP_FIRST = 1'(STOP_BITS - 1);

  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  logic [NCO_WIDTH-1:0] acc_q;
  logic [NCO_WIDTH:0]   acc_sum;
  logic                 tick;

  assign acc_sum = {1'b0, acc_q} + {1'b0, NCO_INCR};
  assign tick    = acc_sum[NCO_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_sum[NCO_WIDTH-1:0];
  end

  rx_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 brk_cand_q, brk_cand_d;
  logic                 brk_wait_q, brk_wait_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 push_q, push_d;
  logic                 brk_pulse_q, brk_pulse_d;
  logic [EW-1:0]        entry_q, entry_d;
  logic                 stop_ferr;
  logic                 stop_brk;
  logic                 par_xor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      brk_cand_q  <= 1'b0;
      brk_wait_q  <= 1'b0;
      rx_prev_q   <= 1'b1;
      push_q      <= 1'b0;
      brk_pulse_q <= 1'b0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      brk_cand_q  <= brk_cand_d;
      brk_wait_q  <= brk_wait_d;
      rx_prev_q   <= rx_prev_d;
      push_q      <= push_d;
      brk_pulse_q <= brk_pulse_d;
      entry_q     <= entry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    brk_cand_d  = brk_cand_q;
    brk_wait_d  = brk_wait_q;
    rx_prev_d   = rx_prev_q;
    push_d      = 1'b0;
    brk_pulse_d = 1'b0;
    entry_d     = entry_q;
    par_xor     = ^{data_q, rx_sync};
    stop_ferr   = frame_err_q | ~rx_sync;
    // Break is decided on the first stop sample; later stop samples only add frame_err.
    stop_brk    = (stop_cnt_q == STOP_FIRST) ? ((data_q == '0) && !par_bit_q && !rx_sync)
                                             : brk_cand_q;
    if (tick) begin
      rx_prev_d = rx_sync;
      case (state_q)
        ST_IDLE: begin
          if (brk_wait_q) begin
            if (rx_sync) brk_wait_d = 1'b0;
          end else if (rx_prev_q && !rx_sync) begin
            state_d = ST_START;
            cnt_d   = HALF_LAST;
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            if (!rx_sync) begin
              state_d     = ST_DATA;
              cnt_d       = BIT_LAST;
              bit_cnt_d   = DATA_FIRST;
              par_bit_d   = 1'b0;
              par_err_d   = 1'b0;
              frame_err_d = 1'b0;
              brk_cand_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            data_d = {rx_sync, data_q[DATA_BITS-1:1]};
            cnt_d  = BIT_LAST;
            if (bit_cnt_q == '0) begin
              stop_cnt_d = STOP_FIRST;
              state_d    = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt_q == '0) begin
            par_bit_d  = rx_sync;
            par_err_d  = (PARITY == PAR_EVEN) ? par_xor :
                         (PARITY == PAR_ODD)  ? ~par_xor : 1'b0;
            stop_cnt_d = STOP_FIRST;
            cnt_d      = BIT_LAST;
            state_d    = ST_STOP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            frame_err_d = stop_ferr;
            brk_cand_d  = stop_brk;
            if (stop_cnt_q == 1'b0) begin
              state_d = ST_IDLE;
              if (stop_brk) begin
                brk_pulse_d = 1'b1;
                brk_wait_d  = 1'b1;
              end else begin
                push_d  = 1'b1;
                entry_d = {data_q, par_err_q, stop_ferr};
              end
            end else begin
              stop_cnt_d = 1'b0;
              cnt_d      = BIT_LAST;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          overrun_q;
  logic [EW-1:0] fifo_rdata;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign {m_data, m_parity_err, m_frame_err} = fifo_rdata;

  uart_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .wdata (entry_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A frame arriving to a full FIFO is dropped unless the consumer frees a slot that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= push_q && fifo_full && !pop;
  end

  assign overrun   = overrun_q;
  assign break_det = brk_pulse_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream: three configurations (8N1, 8E1, 8N1 with a 4-deep FIFO) run in parallel.
module tb_uart_rx_stream;
  import uart_pkg::*;

  localparam int BIT_T    = 8680;  // one bit time at 115200 baud with a 10-unit clock
  localparam int GLITCH_T = 3260;  // about 6 oversample ticks

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] x_data;
    logic       x_perr;
    logic       x_ferr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic rst_a_n = 1'b0, rst_p_n = 1'b0, rst_f_n = 1'b0;
  logic rx_a = 1'b1, rx_p = 1'b1, rx_f = 1'b1;
  logic ready_a = 1'b1, ready_p = 1'b1, ready_f = 1'b0;

  logic [7:0] data_a, data_p, data_f;
  logic perr_a, perr_p, perr_f, ferr_a, ferr_p, ferr_f;
  logic valid_a, valid_p, valid_f, ovr_a, ovr_p, ovr_f, brk_a, brk_p, brk_f;
  logic [4:0] level_a, level_p;
  logic [2:0] level_f;

  uart_rx_stream dut_a (
    .clk(clk), .rst_n(rst_a_n), .uart_rx(rx_a),
    .m_data(data_a), .m_parity_err(perr_a), .m_frame_err(ferr_a), .m_valid(valid_a), .m_ready(ready_a),
    .overrun(ovr_a), .break_det(brk_a), .fifo_level(level_a)
  );

  uart_rx_stream #(.PARITY(PAR_EVEN)) dut_p (
    .clk(clk), .rst_n(rst_p_n), .uart_rx(rx_p),
    .m_data(data_p), .m_parity_err(perr_p), .m_frame_err(ferr_p), .m_valid(valid_p), .m_ready(ready_p),
    .overrun(ovr_p), .break_det(brk_p), .fifo_level(level_p)
  );

  uart_rx_stream #(.FIFO_DEPTH(4)) dut_f (
    .clk(clk), .rst_n(rst_f_n), .uart_rx(rx_f),
    .m_data(data_f), .m_parity_err(perr_f), .m_frame_err(ferr_f), .m_valid(valid_f), .m_ready(ready_f),
    .overrun(ovr_f), .break_det(brk_f), .fifo_level(level_f)
  );

  exp_t q_a[$], q_p[$], q_f[$];
  exp_t ea, ep, ef;
  int pops_a = 0, pops_p = 0, pops_f = 0;
  int brks_a = 0, brks_p = 0, brks_f = 0;
  int ovrs_a = 0, ovrs_p = 0, ovrs_f = 0;
  int vcyc_a = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void push_exp(input int d, input exp_t e);
    case (d)
      0:       q_a.push_back(e);
      1:       q_p.push_back(e);
      default: q_f.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q_a.size();
      1:       return q_p.size();
      default: return q_f.size();
    endcase
  endfunction

  task automatic drive(input int d, input logic v);
    case (d)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_f = v;
    endcase
  endtask

  task automatic send(input int d, input logic [7:0] data, input bit has_par,
                      input logic par_bit, input logic stop_bit);
    drive(d, 1'b0); #BIT_T;
    for (int b = 0; b < 8; b++) begin
      drive(d, data[b]); #BIT_T;
    end
    if (has_par) begin
      drive(d, par_bit); #BIT_T;
    end
    drive(d, stop_bit); #BIT_T;
    drive(d, 1'b1); #BIT_T;
  endtask

  task automatic wait_empty(input int d, input int limit, input string name);
    for (int i = 0; i < limit && qsize(d) != 0; i++) #10;
    chk(name, qsize(d), 0);
  endtask

  // Scoreboard monitors: compare the head entry whenever a handshake will occur at the next edge.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      if (q_a.size() == 0) chk("a_unexpected_entry", {data_a, perr_a, ferr_a}, 32'hFFFF_FFFF);
      else begin
        ea = q_a.pop_front();
        chk("a_data", data_a, ea.data);
        chk("a_perr", perr_a, ea.perr);
        chk("a_ferr", ferr_a, ea.ferr);
        pops_a++;
      end
    end
    if (valid_a) vcyc_a++;
    if (brk_a) brks_a++;
    if (ovr_a) ovrs_a++;
  end

  always @(negedge clk) begin
    if (valid_p && ready_p) begin
      if (q_p.size() == 0) chk("p_unexpected_entry", {data_p, perr_p, ferr_p}, 32'hFFFF_FFFF);
      else begin
        ep = q_p.pop_front();
        chk("p_data", data_p, ep.data);
        chk("p_perr", perr_p, ep.perr);
        chk("p_ferr", ferr_p, ep.ferr);
        pops_p++;
      end
    end
    if (brk_p) brks_p++;
    if (ovr_p) ovrs_p++;
  end

  always @(negedge clk) begin
    if (valid_f && ready_f) begin
      if (q_f.size() == 0) chk("f_unexpected_entry", {data_f, perr_f, ferr_f}, 32'hFFFF_FFFF);
      else begin
        ef = q_f.pop_front();
        chk("f_data", data_f, ef.data);
        chk("f_perr", perr_f, ef.perr);
        chk("f_ferr", ferr_f, ef.ferr);
        pops_f++;
      end
    end
    if (brk_f) brks_f++;
    if (ovr_f) ovrs_f++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

    #20;
    chk("rst_m_data", data_a, 0);
    chk("rst_m_valid", valid_a, 0);
    chk("rst_perr", perr_a, 0);
    chk("rst_ferr", ferr_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_break", brk_a, 0);
    chk("rst_level", level_a, 0);
    #6;
    rst_a_n = 1'b1; rst_p_n = 1'b1; rst_f_n = 1'b1;
    #(2 * BIT_T);

    fork
      begin : seq_a
        int v0, p0, b0;
        logic [7:0] pc;
        v0 = vcyc_a;
        push_exp(0, '{8'hA5, 1'b0, 1'b0});
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_empty(0, 2000, "a_a5_drain");
        chk("a_a5_valid_width", vcyc_a - v0, 1);

        push_exp(0, '{8'h55, 1'b0, 1'b1});
        send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_empty(0, 2000, "a_55_drain");

        p0 = pops_a;
        drive(0, 1'b0); #GLITCH_T;
        drive(0, 1'b1); #(2 * BIT_T);
        chk("a_glitch_no_entry", pops_a - p0, 0);
        chk("a_glitch_level", level_a, 0);

        p0 = pops_a; b0 = brks_a;
        drive(0, 1'b0); #(12 * BIT_T);
        drive(0, 1'b1); #(2 * BIT_T);
        chk("a_break_pulses", brks_a - b0, 1);
        chk("a_break_no_entry", pops_a - p0, 0);

        ready_a = 1'b0;
        push_exp(0, '{8'h7E, 1'b0, 1'b0});
        send(0, 8'h7E, 1'b0, 1'b0, 1'b1);
        #1000;
        chk("a_7e_valid", valid_a, 1);
        chk("a_7e_data", data_a, 8'h7E);
        chk("a_7e_level", level_a, 1);
        #5000;
        chk("a_7e_data_held", data_a, 8'h7E);

        pc = 8'hC3;
        p0 = pops_a;
        drive(0, 1'b0); #BIT_T;
        for (int b = 0; b < 4; b++) begin
          drive(0, pc[b]); #BIT_T;
        end
        drive(0, pc[4]); #(BIT_T / 2);
        rst_a_n = 1'b0;
        #100;
        chk("a_midrst_data", data_a, 0);
        chk("a_midrst_valid", valid_a, 0);
        chk("a_midrst_perr", perr_a, 0);
        chk("a_midrst_ferr", ferr_a, 0);
        chk("a_midrst_overrun", ovr_a, 0);
        chk("a_midrst_break", brk_a, 0);
        chk("a_midrst_level", level_a, 0);
        q_a.delete();
        drive(0, 1'b1); #100;
        rst_a_n = 1'b1;
        #(2 * BIT_T);
        chk("a_postrst_level", level_a, 0);
        chk("a_postrst_no_entry", pops_a - p0, 0);
        ready_a = 1'b1;
        push_exp(0, '{8'hC3, 1'b0, 1'b0});
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_empty(0, 2000, "a_c3_drain");
      end

      begin : seq_p
        for (int i = 0; i < 6; i++) begin
          push_exp(1, '{vecs[i].x_data, vecs[i].x_perr, vecs[i].x_ferr});
          send(1, vecs[i].data, 1'b1, vecs[i].par_bit, vecs[i].stop_bit);
          wait_empty(1, 2000, "p_vec_drain");
        end
        chk("p_no_break", brks_p, 0);
        chk("p_entries", pops_p, 6);
      end

      begin : seq_f
        for (int i = 1; i <= 5; i++) begin
          if (i <= 4) push_exp(2, '{8'(i), 1'b0, 1'b0});
          send(2, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        #1000;
        chk("f_full_level", level_f, 4);
        chk("f_overrun_pulses", ovrs_f, 1);
        chk("f_head_held", data_f, 8'h01);
        chk("f_valid_full", valid_f, 1);
        @(posedge clk); #1;
        ready_f = 1'b1;
        wait_empty(2, 200, "f_drain");
        #100;
        chk("f_drained_level", level_f, 0);
        chk("f_drained_valid", valid_f, 0);
        chk("f_entries", pops_f, 4);
      end
    join

    chk("a_no_overrun", ovrs_a, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
